blink_monitor: RTL and testbench

//  Receive-side counterpart of the LED blink generator. Samples a toggling

---
 rtl/blink_pkg.sv | 20 ++
 rtl/blink_monitor_if.sv | 36 +++
 rtl/blink_edge_det.sv | 27 ++
 rtl/blink_monitor.sv | 132 +++++++++++++
 tb/tb_blink_monitor.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/blink_pkg.sv
// Shared types and default parameter values for the blink monitor slice.
package blink_pkg;

  // Monitor FSM states: IDLE waits for the first edge after reset, MEASURE
  // times complete halves, STUCK means the line has stopped toggling.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } mon_state_t;

  // Default sizing used when the monitor is instantiated without overrides.
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_TIMEOUT  = 50000;
  localparam int DEF_MIN_HALF = 4;

  // Width of the free-running edge counter.
  localparam int TOGGLE_W = 8;

endpackage

// File: rtl/blink_monitor_if.sv
// Bundle of the observed blink line and the measurement results.
// The master side drives the blink line and reads results; the slave side
// (the monitor) samples the line and drives the results.
interface blink_monitor_if #(
  parameter int CNT_W = 16
);

  logic             blink_in;
  logic [CNT_W-1:0] half_cnt;
  logic             half_level;
  logic             half_valid;
  logic             glitch;
  logic             stuck;
  logic [7:0]       toggle_cnt;

  modport master (
    output blink_in,
    input  half_cnt,
    input  half_level,
    input  half_valid,
    input  glitch,
    input  stuck,
    input  toggle_cnt
  );

  modport slave (
    input  blink_in,
    output half_cnt,
    output half_level,
    output half_valid,
    output glitch,
    output stuck,
    output toggle_cnt
  );

endinterface

// File: rtl/blink_edge_det.sv
// Edge detector for the blink line: remembers last cycle's level and flags
// any change. The remembered level is the level of the half that just ended
// whenever an edge is flagged.
module blink_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic blink_i,
  output logic edge_o,
  output logic level_o
);

  logic prev_q;

  // Previous-level register; cleared on reset so a line held high at reset
  // release shows up as one (unreported) first edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= blink_i;
    end
  end

  assign edge_o  = blink_i ^ prev_q;
  assign level_o = prev_q;

endmodule

// File: rtl/blink_monitor.sv
// Receive-side blink monitor: measures each half-period of a toggling line,
// flags halves shorter than MIN_HALF as glitches, and raises stuck when the
// line has not changed for TIMEOUT cycles. TIMEOUT must fit in CNT_W bits.
module blink_monitor
  import blink_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  parameter int MIN_HALF = DEF_MIN_HALF
) (
  input  logic          clk,
  input  logic          rst,
  blink_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] TimeoutC = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MinHalfC = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic                toggled;
  logic                lastLevel;
  logic                atTimeout;
  logic                legalHalf;

  mon_state_t          state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    halfCnt_q;
  logic                halfLevel_q;
  logic                halfValid_q;
  logic                glitch_q;
  logic                stuck_q;
  logic [TOGGLE_W-1:0] toggleCnt_q;
  logic [TOGGLE_W-1:0] toggleCnt_d;

  blink_edge_det u_edge (
    .clk     (clk),
    .rst     (rst),
    .blink_i (bus.blink_in),
    .edge_o  (toggled),
    .level_o (lastLevel)
  );

  // Half-period counter next value: restart at 1 on an edge so that a line
  // toggling every N cycles reads N at its next edge; otherwise count up and
  // pin at TIMEOUT so a dead line never wraps back into a legal-looking value.
  always_comb begin
    cnt_d = cnt_q;
    if (toggled) begin
      cnt_d = CntOne;
    end else if (cnt_q >= TimeoutC) begin
      cnt_d = TimeoutC;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

  // Edge counter next value; wraps naturally at 255 -> 0.
  always_comb begin
    toggleCnt_d = toggleCnt_q;
    if (toggled) begin
      toggleCnt_d = toggleCnt_q + TOGGLE_W'(1);
    end
  end

  // Decode helpers for the FSM, evaluated on the registered count.
  assign atTimeout = (cnt_q == TimeoutC);
  assign legalHalf = (cnt_q >= MinHalfC);

  // Counter, FSM and all result registers. Pulses default low every cycle.
  // An edge always takes priority over the timeout so a half of exactly
  // TIMEOUT cycles is reported rather than flagged stuck.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      halfCnt_q   <= '0;
      halfLevel_q <= 1'b0;
      halfValid_q <= 1'b0;
      glitch_q    <= 1'b0;
      stuck_q     <= 1'b0;
      toggleCnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      toggleCnt_q <= toggleCnt_d;
      halfValid_q <= 1'b0;
      glitch_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (toggled) begin
            state_q <= MEASURE;
          end else if (atTimeout) begin
            state_q <= STUCK;
            stuck_q <= 1'b1;
          end
        end
        MEASURE: begin
          if (toggled) begin
            if (legalHalf) begin
              halfCnt_q   <= cnt_q;
              halfLevel_q <= lastLevel;
              halfValid_q <= 1'b1;
            end else begin
              glitch_q <= 1'b1;
            end
          end else if (atTimeout) begin
            state_q <= STUCK;
            stuck_q <= 1'b1;
          end
        end
        STUCK: begin
          if (toggled) begin
            state_q <= MEASURE;
            stuck_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          stuck_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.half_cnt   = halfCnt_q;
  assign bus.half_level = halfLevel_q;
  assign bus.half_valid = halfValid_q;
  assign bus.glitch     = glitch_q;
  assign bus.stuck      = stuck_q;
  assign bus.toggle_cnt = toggleCnt_q;

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor: a timestamp-based reference model checks every
// cycle, while a segment table and hand sequences pin down the corner cases.
module tb_blink_monitor;

  localparam int CntW     = 16;
  localparam int TimeoutC = 20;
  localparam int MinHalf  = 4;

  localparam int EvNone   = 0;
  localparam int EvValid  = 1;
  localparam int EvGlitch = 2;

  typedef struct packed {
    logic        hv;
    logic        gl;
    logic        st;
    logic        lvl;
    logic [15:0] cnt;
    logic [7:0]  tog;
  } outVec_t;

  typedef struct {
    logic lvl;
    int   len;
    int   ev;
    int   cnt;
    logic hlvl;
    int   tog;
  } segVec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  blink_monitor_if #(.CNT_W(CntW)) bus ();

  blink_monitor #(
    .CNT_W    (CntW),
    .TIMEOUT  (TimeoutC),
    .MIN_HALF (MinHalf)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int      nVec   = 0;
  int      nErr   = 0;
  int      hvSeen = 0;
  int      now    = 0;
  int      mLast  = 0;
  logic    mPrev  = 1'b0;
  logic    mArmed = 1'b0;
  logic    mStuck = 1'b0;
  outVec_t expv   = '0;
  segVec_t segTable [13];

  // Reference model: works from the cycle stamp of the last edge rather than
  // a counter. A half is reported only if an edge has been seen since reset
  // and the line was not stuck; its length is the distance between edges.
  task automatic modelStep(input logic b, input logic r);
    int len;
    now++;
    if (r) begin
      expv   = '0;
      mPrev  = 1'b0;
      mArmed = 1'b0;
      mStuck = 1'b0;
      mLast  = now + 1;
    end else begin
      expv.hv = 1'b0;
      expv.gl = 1'b0;
      len = now - mLast;
      if (b != mPrev) begin
        expv.tog = expv.tog + 8'd1;
        if (mArmed && !mStuck) begin
          if (len >= MinHalf) begin
            expv.hv  = 1'b1;
            expv.cnt = 16'(len);
            expv.lvl = mPrev;
          end else begin
            expv.gl = 1'b1;
          end
        end
        mArmed  = 1'b1;
        mStuck  = 1'b0;
        expv.st = 1'b0;
        mLast   = now;
      end else if (!mStuck && len >= TimeoutC) begin
        mStuck  = 1'b1;
        expv.st = 1'b1;
      end
      mPrev = b;
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic checkOutput(input string tag);
    outVec_t act;
    act = {bus.half_valid, bus.glitch, bus.stuck, bus.half_level,
           bus.half_cnt, bus.toggle_cnt};
    nVec++;
    if (act !== expv) begin
      nErr++;
      $display("[TB] FAIL %s @%0d: got hv=%b gl=%b st=%b lvl=%b cnt=%0d tog=%0d, want hv=%b gl=%b st=%b lvl=%b cnt=%0d tog=%0d",
               tag, now, act.hv, act.gl, act.st, act.lvl, act.cnt, act.tog,
               expv.hv, expv.gl, expv.st, expv.lvl, expv.cnt, expv.tog);
    end
  endtask

  // Compare the DUT against hand-derived values.
  task automatic checkExplicit(input string tag, input logic wHv, input logic wGl,
                               input logic wSt, input logic wLvl, input int wCnt,
                               input int wTog);
    nVec++;
    if (bus.half_valid !== wHv || bus.glitch !== wGl || bus.stuck !== wSt ||
        bus.half_level !== wLvl || bus.half_cnt !== 16'(wCnt) ||
        bus.toggle_cnt !== 8'(wTog)) begin
      nErr++;
      $display("[TB] FAIL %s @%0d: got hv=%b gl=%b st=%b lvl=%b cnt=%0d tog=%0d, want hv=%b gl=%b st=%b lvl=%b cnt=%0d tog=%0d",
               tag, now, bus.half_valid, bus.glitch, bus.stuck, bus.half_level,
               bus.half_cnt, bus.toggle_cnt, wHv, wGl, wSt, wLvl, wCnt, wTog);
    end
  endtask

  // One clock cycle: drive inputs, clock, advance model, sample 1 unit later.
  task automatic applyStimulus(input logic b, input logic r, input string tag);
    bus.blink_in = b;
    rst          = r;
    @(posedge clk);
    modelStep(b, r);
    #1;
    checkOutput(tag);
    if (bus.half_valid === 1'b1) hvSeen++;
  endtask

  // Main sequence: reset, segment table, stuck, reset-abort, wrap, random.
  initial begin
    logic lvl;
    int   len;

    segTable[0]  = '{1'b1,  5, EvNone,    0, 1'b0,  1};
    segTable[1]  = '{1'b0,  5, EvValid,   5, 1'b1,  2};
    segTable[2]  = '{1'b1,  5, EvValid,   5, 1'b0,  3};
    segTable[3]  = '{1'b0, 10, EvValid,   5, 1'b1,  4};
    segTable[4]  = '{1'b1,  2, EvValid,  10, 1'b0,  5};
    segTable[5]  = '{1'b0,  8, EvGlitch, 10, 1'b0,  6};
    segTable[6]  = '{1'b1,  4, EvValid,   8, 1'b0,  7};
    segTable[7]  = '{1'b0,  3, EvValid,   4, 1'b1,  8};
    segTable[8]  = '{1'b1, 20, EvGlitch,  4, 1'b1,  9};
    segTable[9]  = '{1'b0,  6, EvValid,  20, 1'b1, 10};
    segTable[10] = '{1'b1,  1, EvValid,   6, 1'b0, 11};
    segTable[11] = '{1'b0,  5, EvGlitch,  6, 1'b0, 12};
    segTable[12] = '{1'b1,  5, EvValid,   5, 1'b0, 13};

    bus.blink_in = 1'b0;
    applyStimulus(1'b0, 1'b1, "reset");
    applyStimulus(1'b0, 1'b1, "reset");
    checkExplicit("reset-state", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

    for (int i = 0; i < 13; i++) begin
      for (int j = 0; j < segTable[i].len; j++) begin
        applyStimulus(segTable[i].lvl, 1'b0, "segment");
        if (j == 0)
          checkExplicit("segment-edge", segTable[i].ev == EvValid,
                        segTable[i].ev == EvGlitch, 1'b0, segTable[i].hlvl,
                        segTable[i].cnt, segTable[i].tog);
      end
    end

    for (int j = 5; j < 20; j++) applyStimulus(1'b1, 1'b0, "pre-stuck");
    checkExplicit("stuck-not-yet", 1'b0, 1'b0, 1'b0, 1'b0, 5, 13);
    applyStimulus(1'b1, 1'b0, "stuck-rise");
    checkExplicit("stuck-rise", 1'b0, 1'b0, 1'b1, 1'b0, 5, 13);
    repeat (3) applyStimulus(1'b1, 1'b0, "stuck-hold");
    applyStimulus(1'b0, 1'b0, "stuck-clear");
    checkExplicit("stuck-clear", 1'b0, 1'b0, 1'b0, 1'b0, 5, 14);
    repeat (5) applyStimulus(1'b0, 1'b0, "after-stuck");
    applyStimulus(1'b1, 1'b0, "after-stuck-edge");
    checkExplicit("after-stuck-half", 1'b1, 1'b0, 1'b0, 1'b0, 6, 15);

    repeat (4) applyStimulus(1'b1, 1'b0, "pre-abort");
    applyStimulus(1'b0, 1'b0, "pre-abort");
    repeat (2) applyStimulus(1'b0, 1'b0, "pre-abort");
    applyStimulus(1'b0, 1'b1, "abort-reset");
    checkExplicit("abort-reset", 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, "abort-wait");
    applyStimulus(1'b1, 1'b0, "abort-first-edge");
    checkExplicit("abort-first-edge", 1'b0, 1'b0, 1'b0, 1'b0, 0, 1);
    repeat (4) applyStimulus(1'b1, 1'b0, "abort-hold");
    applyStimulus(1'b0, 1'b0, "abort-second-edge");
    checkExplicit("abort-second-edge", 1'b1, 1'b0, 1'b0, 1'b1, 5, 2);

    applyStimulus(1'b0, 1'b1, "wrap-reset");
    hvSeen = 0;
    lvl = 1'b0;
    for (int e = 0; e < 256; e++) begin
      lvl = ~lvl;
      repeat (5) applyStimulus(lvl, 1'b0, "wrap");
    end
    checkExplicit("wrap-toggle", 1'b0, 1'b0, 1'b0, ~lvl, 5, 0);
    nVec++;
    if (hvSeen != 255) begin
      nErr++;
      $display("[TB] FAIL wrap-valid-count: got %0d, want 255", hvSeen);
    end

    lvl = bus.blink_in;
    repeat (160) begin
      if ($urandom_range(0, 19) == 0) applyStimulus(lvl, 1'b1, "rand-reset");
      lvl = ~lvl;
      len = int'($urandom_range(1, 26));
      for (int j = 0; j < len; j++) applyStimulus(lvl, 1'b0, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
